csr_file: RTL and testbench
===========================

# csr_file

Next-generation LoongArch control/status register file for the core's fetch/commit path. It holds the privilege, exception and timer CSRs and services one combinational read port and one masked write port (csrwr/csrxchg). It also provides commit-time exception entry and `ertn` return, a constant-period timer and interrupt aggregation. Width, save-register count and hardware-interrupt count are parametrised.

## Interface
- `TIMER_WIDTH`, 32: timer counter width, legal 8..32; TCFG/TVAL bits at and above this width read 0.
- `SAVE_NUM`, 4: number of SAVEn scratch CSRs (0x30..0x30+SAVE_NUM-1), legal 1..16.
- `HW_INT_NUM`, 8: hardware interrupt lines mapped to ESTAT.IS[2+HW_INT_NUM-1:2], legal 1..8.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `csr_raddr` in 14: read address.
- `csr_rdata` out 32: combinational read data; 0 for unimplemented addresses.
- `csr_wr_en` in 1: write strobe.
- `csr_waddr` in 14: write address.
- `csr_wdata` in 32: write data.
- `csr_wmask` in 32: bit-enable mask; all-ones for csrwr.
- `excp_valid` in 1: commit an exception this cycle.
- `excp_ecode` in 6: Ecode for the committed exception.
- `excp_esubcode` in 9: EsubCode for the committed exception.
- `excp_pc` in 32: PC of the faulting instruction.
- `excp_badv_we` in 1: update BADV on exception.
- `excp_badv` in 32: faulting virtual address.
- `ertn_valid` in 1: commit `ertn` this cycle.
- `hw_int` in HW_INT_NUM: level interrupt lines.
- `ipi_int` in 1: inter-processor interrupt, level.
- `int_req` out 1: interrupt pending and enabled.
- `excp_entry` out 32: EENTRY value.
- `ertn_pc` out 32: ERA value.
- `crmd_plv` out 2: current privilege level.
- `crmd_da` out 1: direct-address mode.
- `crmd_pg` out 1: paged mode.

## Operation
- CRMD: PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7]; reset 0x0000_0008.
- PRMD: PPLV[1:0], PIE[2]; reset 0.
- ECFG: LIE[12:0], with bit 10 read-only 0; reset 0.
- ESTAT: IS[1:0] software-writable; IS[9:2] hardware; IS[11] timer; IS[12] IPI; Ecode[21:16], EsubCode[30:22] read-only to software; reset 0.
- ERA, BADV, SAVEn, TID: full 32 bits, reset 0.
- EENTRY: VA[31:6] writable, [5:0] read 0; reset 0.
- TCFG: En[0], Periodic[1], InitVal[TIMER_WIDTH-1:2]; reset 0.
- TVAL: read-only; reset all-ones within TIMER_WIDTH.
- TICLR: write 1 to bit 0 clears IS[11]; always reads 0.
- Masked write: `new = (old & ~mask) | (wdata & mask)`, applied only to writable bits.
- Exception entry (`excp_valid`):
  - PRMD.PPLV←CRMD.PLV, PRMD.PIE←CRMD.IE.
  - CRMD.PLV←0, CRMD.IE←0.
  - ERA←excp_pc; ESTAT.Ecode/EsubCode loaded.
  - BADV←excp_badv if `excp_badv_we`.
- `ertn`: CRMD.PLV←PRMD.PPLV, CRMD.IE←PRMD.PIE.
- `excp_valid` and `ertn_valid` are mutually exclusive; the bench asserts this.
- Simultaneous exception or `ertn` plus CSR write to the same register: the exception/`ertn` update wins for the fields it touches; other fields take the write.
- IS[9:2] and IS[12] are sampled from `hw_int`/`ipi_int` every cycle.
- `int_req = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0])`, combinational from registers.

## Timing
- Writes take effect at the next `clk` edge; reads show the pre-write value in the write cycle, with no bypass.
- Interrupt input to IS visible: 1 cycle. IS to `int_req`: 0 cycles.
- Timer load and countdown:
  - A TCFG write with En=1 loads TVAL←{InitVal,2'b00} at the same edge.
  - While En=1 and TVAL≠0, TVAL decrements by 1 per cycle.
- Timer expiry:
  - On the edge where TVAL goes 1→0, IS[11]←1.
  - Periodic=1: the next edge reloads {InitVal,2'b00}.
  - Periodic=0: TVAL holds 0 with no further interrupts until TCFG is rewritten.
- Timer/TICLR collision: if IS[11] set and a TICLR clear happen in the same cycle, set wins.
- Writing TCFG with En=0 freezes TVAL.
- Asynchronous reset mid-operation returns every register and output to its reset value immediately.
- Outputs at reset: `int_req`=0, `excp_entry`=0, `ertn_pc`=0, `crmd_plv`=0, `crmd_da`=1, `crmd_pg`=0.

## Structure
- Package `csr_pkg`: all 14-bit CSR address constants, field bit-range constants (PLV, IE, DA, PG, DATF, DATM, PPLV, PIE, LIE, IS, Ecode, EsubCode, TCFG fields) and the CRMD reset value.
- Sub-module `csr_timer`:
  - Holds TVAL and the reload/expiry logic.
  - Inputs: TCFG fields and the TCFG write strobe.
  - Outputs: TVAL and a 1-cycle `timer_fire` pulse.

## Test plan
- Reset, then read CRMD → 0x8; read TVAL → 0xFFFF_FFFF; `int_req`=0.
- csrxchg SAVE1: wdata=0xAAAA_5555, mask=0x0000_FFFF over old 0x1234_5678 → next-cycle read 0x1234_5555.
- CRMD=0x7 (PLV3, IE), then `excp_valid` with ecode 0x0B, pc 0x1C00_0100:
  - CRMD.PLV=0, IE=0; PRMD=0x7; ERA=0x1C00_0100; ESTAT[21:16]=0x0B.
  - `ertn` the next cycle → CRMD.PLV=3, IE=1.
- TCFG=0x13 (InitVal 4, periodic, En):
  - TVAL runs 16→0; IS[11] sets at that edge; TVAL reloads 16 next cycle.
  - TICLR=1 clears IS[11] unless re-fired in the same cycle.
- ECFG.LIE[2]=1, CRMD.IE=1, `hw_int[0]`=1 → `int_req` rises 1 cycle later. Dropping IE → `int_req`=0 the next cycle.
- Assert `reset` asynchronously mid-countdown → all CSRs return to their reset values before the next edge.

Source files
------------

// File: rtl/csr_pkg.sv
`default_nettype none
// csr_pkg: CSR addresses, field positions and write masks for csr_file.
// Rev 1.0
package csr_pkg;
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int PLV_LO  = 0;
  localparam int PLV_HI  = 1;
  localparam int IE_BIT  = 2;
  localparam int DA_BIT  = 3;
  localparam int PG_BIT  = 4;
  localparam int DATF_LO = 5;
  localparam int DATF_HI = 6;
  localparam int DATM_LO = 7;
  localparam int DATM_HI = 8;

  localparam int PPLV_LO = 0;
  localparam int PPLV_HI = 1;
  localparam int PIE_BIT = 2;

  localparam int LIE_LO  = 0;
  localparam int LIE_HI  = 12;

  localparam int IS_LO      = 0;
  localparam int IS_HI      = 12;
  localparam int IS_SW_HI   = 1;
  localparam int IS_HW_LO   = 2;
  localparam int IS_HW_HI   = 9;
  localparam int IS_RSVD    = 10;
  localparam int IS_TI_BIT  = 11;
  localparam int IS_IPI_BIT = 12;
  localparam int ECODE_LO   = 16;
  localparam int ECODE_HI   = 21;
  localparam int ESUB_LO    = 22;
  localparam int ESUB_HI    = 30;

  localparam int TCFG_EN_BIT  = 0;
  localparam int TCFG_PER_BIT = 1;
  localparam int TCFG_INIT_LO = 2;

  localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;
  localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (wdata & mask);
  endfunction
endpackage
`default_nettype wire

// File: rtl/csr_timer.sv
`default_nettype none
// csr_timer: TVAL countdown with load-on-TCFG-write, periodic reload and expiry pulse.
// Rev 1.0
module csr_timer #(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tcfg_we,
  input  logic                   new_en,
  input  logic [TIMER_WIDTH-3:0] new_initval,
  input  logic                   en,
  input  logic                   periodic,
  input  logic [TIMER_WIDTH-3:0] initval,
  output logic [TIMER_WIDTH-1:0] tval,
  output logic                   timer_fire
);
  // A TCFG write takes priority, so a load on the 1->0 edge suppresses the pulse.
  assign timer_fire = en && !tcfg_we && (tval == TIMER_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tval <= '1;
    end else if (tcfg_we) begin
      if (new_en) tval <= {new_initval, 2'b00};
    end else if (en) begin
      if (tval != '0)    tval <= tval - TIMER_WIDTH'(1);
      else if (periodic) tval <= {initval, 2'b00};
    end
  end
endmodule
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// csr_file: privilege/exception/timer CSRs with masked write, exception entry, ertn and interrupts.
// Rev 1.0
module csr_file
  import csr_pkg::*;
#(
  parameter int TIMER_WIDTH = 32,
  parameter int SAVE_NUM    = 4,
  parameter int HW_INT_NUM  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [13:0]           csr_raddr,
  output logic [31:0]           csr_rdata,
  input  logic                  csr_wr_en,
  input  logic [13:0]           csr_waddr,
  input  logic [31:0]           csr_wdata,
  input  logic [31:0]           csr_wmask,
  input  logic                  excp_valid,
  input  logic [5:0]            excp_ecode,
  input  logic [8:0]            excp_esubcode,
  input  logic [31:0]           excp_pc,
  input  logic                  excp_badv_we,
  input  logic [31:0]           excp_badv,
  input  logic                  ertn_valid,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  ipi_int,
  output logic                  int_req,
  output logic [31:0]           excp_entry,
  output logic [31:0]           ertn_pc,
  output logic [1:0]            crmd_plv,
  output logic                  crmd_da,
  output logic                  crmd_pg
);
  localparam logic [31:0] TCFG_MASK =
    (TIMER_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'h1 << TIMER_WIDTH) - 32'h1);

  logic [31:0] crmd, prmd, ecfg, era, badv, eentry, tid, tcfg;
  logic [12:0] estat_is;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esub;
  logic [31:0] save [SAVE_NUM];
  logic [TIMER_WIDTH-1:0] tval;
  logic        timer_fire;
  logic [7:0]  hw_pad;
  logic [31:0] tcfg_wval;

  function automatic logic hit(input logic [13:0] a);
    return csr_wr_en && (csr_waddr == a);
  endfunction

  always_comb begin
    hw_pad = '0;
    hw_pad[HW_INT_NUM-1:0] = hw_int;
  end

  // Exception/ertn assignments come last so they win over a same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd <= CRMD_RESET;
      prmd <= '0;
    end else begin
      if (hit(CSR_CRMD)) crmd <= masked_write(crmd, csr_wdata, csr_wmask) & CRMD_WMASK;
      if (hit(CSR_PRMD)) prmd <= masked_write(prmd, csr_wdata, csr_wmask) & PRMD_WMASK;
      if (excp_valid) begin
        crmd[PLV_HI:PLV_LO]   <= 2'b00;
        crmd[IE_BIT]          <= 1'b0;
        prmd[PPLV_HI:PPLV_LO] <= crmd[PLV_HI:PLV_LO];
        prmd[PIE_BIT]         <= crmd[IE_BIT];
      end else if (ertn_valid) begin
        crmd[PLV_HI:PLV_LO] <= prmd[PPLV_HI:PPLV_LO];
        crmd[IE_BIT]        <= prmd[PIE_BIT];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecfg   <= '0;
      era    <= '0;
      badv   <= '0;
      eentry <= '0;
      tid    <= '0;
    end else begin
      if (hit(CSR_ECFG))   ecfg   <= masked_write(ecfg, csr_wdata, csr_wmask) & ECFG_WMASK;
      if (hit(CSR_EENTRY)) eentry <= masked_write(eentry, csr_wdata, csr_wmask) & EENTRY_WMASK;
      if (hit(CSR_TID))    tid    <= masked_write(tid, csr_wdata, csr_wmask);
      if (hit(CSR_ERA))    era    <= masked_write(era, csr_wdata, csr_wmask);
      if (hit(CSR_BADV))   badv   <= masked_write(badv, csr_wdata, csr_wmask);
      if (excp_valid)                 era  <= excp_pc;
      if (excp_valid && excp_badv_we) badv <= excp_badv;
    end
  end

  // Timer set beats a same-cycle TICLR clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estat_is    <= '0;
      estat_ecode <= '0;
      estat_esub  <= '0;
    end else begin
      if (hit(CSR_ESTAT))
        estat_is[IS_SW_HI:IS_LO] <= (estat_is[IS_SW_HI:IS_LO] & ~csr_wmask[IS_SW_HI:IS_LO])
                                  | (csr_wdata[IS_SW_HI:IS_LO] & csr_wmask[IS_SW_HI:IS_LO]);
      estat_is[IS_HW_HI:IS_HW_LO] <= hw_pad;
      estat_is[IS_RSVD]           <= 1'b0;
      estat_is[IS_IPI_BIT]        <= ipi_int;
      estat_is[IS_TI_BIT]         <= timer_fire |
        (estat_is[IS_TI_BIT] & ~(hit(CSR_TICLR) & csr_wdata[0] & csr_wmask[0]));
      if (excp_valid) begin
        estat_ecode <= excp_ecode;
        estat_esub  <= excp_esubcode;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SAVE_NUM; i++) save[i] <= '0;
    end else begin
      for (int i = 0; i < SAVE_NUM; i++)
        if (hit(CSR_SAVE0 + 14'(i))) save[i] <= masked_write(save[i], csr_wdata, csr_wmask);
    end
  end

  assign tcfg_wval = masked_write(tcfg, csr_wdata, csr_wmask) & TCFG_MASK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               tcfg <= '0;
    else if (hit(CSR_TCFG))  tcfg <= tcfg_wval;
  end

  csr_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .tcfg_we     (hit(CSR_TCFG)),
    .new_en      (tcfg_wval[TCFG_EN_BIT]),
    .new_initval (tcfg_wval[TIMER_WIDTH-1:TCFG_INIT_LO]),
    .en          (tcfg[TCFG_EN_BIT]),
    .periodic    (tcfg[TCFG_PER_BIT]),
    .initval     (tcfg[TIMER_WIDTH-1:TCFG_INIT_LO]),
    .tval        (tval),
    .timer_fire  (timer_fire)
  );

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_CRMD:   csr_rdata = crmd;
      CSR_PRMD:   csr_rdata = prmd;
      CSR_ECFG:   csr_rdata = ecfg;
      CSR_ESTAT:  csr_rdata = {1'b0, estat_esub, estat_ecode, 3'b000, estat_is};
      CSR_ERA:    csr_rdata = era;
      CSR_BADV:   csr_rdata = badv;
      CSR_EENTRY: csr_rdata = eentry;
      CSR_TID:    csr_rdata = tid;
      CSR_TCFG:   csr_rdata = tcfg;
      CSR_TVAL:   csr_rdata = 32'(tval);
      CSR_TICLR:  csr_rdata = '0;
      default: begin
        for (int i = 0; i < SAVE_NUM; i++)
          if (csr_raddr == CSR_SAVE0 + 14'(i)) csr_rdata = save[i];
      end
    endcase
  end

  assign int_req    = crmd[IE_BIT] & |(estat_is & ecfg[LIE_HI:LIE_LO]);
  assign excp_entry = eentry;
  assign ertn_pc    = era;
  assign crmd_plv   = crmd[PLV_HI:PLV_LO];
  assign crmd_da    = crmd[DA_BIT];
  assign crmd_pg    = crmd[PG_BIT];
endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// tb_csr_file: table-driven CSR access checks plus exception, timer, interrupt and reset sequences.
// Rev 1.0
module tb_csr_file;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata, csr_wmask;
  logic        csr_wr_en;
  logic        excp_valid, excp_badv_we, ertn_valid, ipi_int;
  logic [5:0]  excp_ecode;
  logic [8:0]  excp_esubcode;
  logic [31:0] excp_pc, excp_badv;
  logic [7:0]  hw_int;
  logic        int_req, crmd_da, crmd_pg;
  logic [31:0] excp_entry, ertn_pc;
  logic [1:0]  crmd_plv;

  csr_file #(.TIMER_WIDTH(32), .SAVE_NUM(4), .HW_INT_NUM(8)) dut (
    .clk(clk), .reset(reset),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wr_en(csr_wr_en), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
    .excp_valid(excp_valid), .excp_ecode(excp_ecode), .excp_esubcode(excp_esubcode),
    .excp_pc(excp_pc), .excp_badv_we(excp_badv_we), .excp_badv(excp_badv),
    .ertn_valid(ertn_valid), .hw_int(hw_int), .ipi_int(ipi_int),
    .int_req(int_req), .excp_entry(excp_entry), .ertn_pc(ertn_pc),
    .crmd_plv(crmd_plv), .crmd_da(crmd_da), .crmd_pg(crmd_pg)
  );

  always #10 clk = ~clk;

  always @(posedge clk)
    assert (!(excp_valid && ertn_valid)) else $error("FAIL excp_ertn_exclusive");

  initial begin
    #400000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "watchdog");
  end

  int n_run  = 0;
  int n_fail = 0;

  typedef struct { string name; logic [31:0] exp; } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [31:0] mask;
    string       name;
  } vec_t;
  vec_t vecs[$];

  localparam logic [31:0] EST = 32'h0001_0000;  // ESTAT Ecode left by the last exception

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    csr_raddr = a;
    #1;
    e = sb_q.pop_front();
    check(e.name, csr_rdata, e.exp);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    csr_wr_en = 1'b1; csr_waddr = a; csr_wdata = d; csr_wmask = m;
    step();
    csr_wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    csr_raddr = '0; csr_waddr = '0; csr_wdata = '0; csr_wmask = '0; csr_wr_en = 1'b0;
    excp_valid = 1'b0; excp_ecode = '0; excp_esubcode = '0; excp_pc = '0;
    excp_badv_we = 1'b0; excp_badv = '0; ertn_valid = 1'b0; hw_int = '0; ipi_int = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    rd(CSR_CRMD,  32'h0000_0008, "reset_crmd");
    rd(CSR_TVAL,  32'hFFFF_FFFF, "reset_tval");
    rd(CSR_ESTAT, 32'h0, "reset_estat");
    check("reset_int_req", {31'b0, int_req}, 32'h0);
    check("reset_excp_entry", excp_entry, 32'h0);
    check("reset_ertn_pc", ertn_pc, 32'h0);
    check("reset_da_plv_pg", {29'b0, crmd_da, crmd_plv}, 32'h4);
    check("reset_pg", {31'b0, crmd_pg}, 32'h0);

    vecs.push_back(vec_t'{1'b1, 14'h031,    32'h1234_5678, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, 14'h031,    32'h1234_5678, 32'h0, "save1_full"});
    vecs.push_back(vec_t'{1'b1, 14'h031,    32'hAAAA_5555, 32'h0000_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, 14'h031,    32'h1234_5555, 32'h0, "save1_xchg"});
    vecs.push_back(vec_t'{1'b1, CSR_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_EENTRY, 32'hFFFF_FFC0, 32'h0, "eentry_mask"});
    vecs.push_back(vec_t'{1'b1, CSR_ECFG,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_ECFG,   32'h0000_1BFF, 32'h0, "ecfg_mask"});
    vecs.push_back(vec_t'{1'b1, CSR_ECFG,   32'h0,         32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_ECFG,   32'h0,         32'h0, "ecfg_clear"});
    vecs.push_back(vec_t'{1'b1, CSR_ESTAT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_ESTAT,  32'h0000_0003, 32'h0, "estat_sw_only"});
    vecs.push_back(vec_t'{1'b1, CSR_ESTAT,  32'h0,         32'h0000_0001, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_ESTAT,  32'h0000_0002, 32'h0, "estat_xchg"});
    vecs.push_back(vec_t'{1'b1, CSR_ESTAT,  32'h0,         32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b1, CSR_PRMD,   32'h0000_00FF, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_PRMD,   32'h0000_0007, 32'h0, "prmd_mask"});
    vecs.push_back(vec_t'{1'b1, CSR_PRMD,   32'h0,         32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b1, CSR_TID,    32'hDEAD_BEEF, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_TID,    32'hDEAD_BEEF, 32'h0, "tid"});
    vecs.push_back(vec_t'{1'b1, 14'h033,    32'hCAFE_F00D, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, 14'h033,    32'hCAFE_F00D, 32'h0, "save3"});
    vecs.push_back(vec_t'{1'b0, 14'h030,    32'h0,         32'h0, "save0_untouched"});
    vecs.push_back(vec_t'{1'b0, 14'h034,    32'h0,         32'h0, "save_beyond_last"});
    vecs.push_back(vec_t'{1'b0, 14'h002,    32'h0,         32'h0, "unimplemented"});
    vecs.push_back(vec_t'{1'b1, CSR_TICLR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_TICLR,  32'h0,         32'h0, "ticlr_reads_0"});
    vecs.push_back(vec_t'{1'b1, CSR_TCFG,   32'h0000_0012, 32'hFFFF_FFFF, "w"});
    vecs.push_back(vec_t'{1'b0, CSR_TCFG,   32'h0000_0012, 32'h0, "tcfg_en0"});
    vecs.push_back(vec_t'{1'b0, CSR_TVAL,   32'hFFFF_FFFF, 32'h0, "tval_not_loaded_en0"});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data, vecs[i].mask);
      else            rd(vecs[i].addr, vecs[i].data, vecs[i].name);
    end

    // Exception entry and return.
    wr(CSR_CRMD, 32'h7, 32'hFFFF_FFFF);
    rd(CSR_CRMD, 32'h7, "crmd_plv3_ie");
    excp_valid = 1'b1; excp_ecode = 6'h0B; excp_esubcode = 9'h0; excp_pc = 32'h1C00_0100;
    excp_badv_we = 1'b1; excp_badv = 32'h0000_BEEF;
    step();
    excp_valid = 1'b0; excp_badv_we = 1'b0;
    rd(CSR_CRMD,  32'h0,           "excp_crmd");
    rd(CSR_PRMD,  32'h7,           "excp_prmd");
    rd(CSR_ERA,   32'h1C00_0100,   "excp_era");
    rd(CSR_ESTAT, 32'h000B_0000,   "excp_estat_ecode");
    rd(CSR_BADV,  32'h0000_BEEF,   "excp_badv");
    check("excp_ertn_pc", ertn_pc, 32'h1C00_0100);
    ertn_valid = 1'b1;
    step();
    ertn_valid = 1'b0;
    check("ertn_plv", {30'b0, crmd_plv}, 32'h3);
    rd(CSR_CRMD, 32'h7, "ertn_crmd");

    // Exception colliding with a CRMD write: PLV/IE from the exception, DA/PG from the write.
    csr_wr_en = 1'b1; csr_waddr = CSR_CRMD; csr_wdata = 32'h1F; csr_wmask = 32'hFFFF_FFFF;
    excp_valid = 1'b1; excp_ecode = 6'h01; excp_pc = 32'h1C00_0200; excp_badv = 32'h1111_1111;
    step();
    csr_wr_en = 1'b0; excp_valid = 1'b0;
    rd(CSR_CRMD,  32'h18, "collide_crmd");
    rd(CSR_PRMD,  32'h7,  "collide_prmd");
    rd(CSR_ESTAT, EST,    "collide_estat");
    rd(CSR_BADV,  32'h0000_BEEF, "badv_we_low_holds");
    wr(CSR_CRMD, 32'h8, 32'hFFFF_FFFF);

    // Periodic timer: InitVal 4 -> reload value 16.
    wr(CSR_TCFG, 32'h13, 32'hFFFF_FFFF);
    for (int v = 16; v >= 1; v--) begin
      rd(CSR_TVAL, 32'(v), "tval_countdown");
      step();
    end
    rd(CSR_TVAL,  32'h0,                "tval_expired");
    rd(CSR_ESTAT, EST | 32'h800,        "timer_is11_set");
    step();
    rd(CSR_TVAL,  32'd16,               "tval_periodic_reload");
    wr(CSR_TICLR, 32'h1, 32'hFFFF_FFFF);
    rd(CSR_ESTAT, EST,                  "ticlr_clears");
    rd(CSR_TVAL,  32'd15,               "tval_after_reload");
    repeat (14) step();
    rd(CSR_TVAL,  32'd1,                "tval_before_collide");
    wr(CSR_TICLR, 32'h1, 32'hFFFF_FFFF);
    rd(CSR_ESTAT, EST | 32'h800,        "ticlr_vs_fire_set_wins");

    // En=0 freezes, then a one-shot run.
    wr(CSR_TCFG, 32'h0, 32'hFFFF_FFFF);
    step();
    rd(CSR_TVAL,  32'h0,                "tval_frozen_no_reload");
    wr(CSR_TICLR, 32'h1, 32'hFFFF_FFFF);
    wr(CSR_TCFG, 32'h5, 32'hFFFF_FFFF);
    rd(CSR_TVAL,  32'd4,                "oneshot_load");
    repeat (4) step();
    rd(CSR_ESTAT, EST | 32'h800,        "oneshot_fire");
    wr(CSR_TICLR, 32'h1, 32'hFFFF_FFFF);
    repeat (3) step();
    rd(CSR_TVAL,  32'h0,                "oneshot_holds_0");
    rd(CSR_ESTAT, EST,                  "oneshot_no_refire");

    // Hardware interrupt path.
    wr(CSR_ECFG, 32'h4, 32'hFFFF_FFFF);
    wr(CSR_CRMD, 32'h4, 32'hFFFF_FFFF);
    hw_int = 8'h01;
    #1;
    check("int_req_before_sample", {31'b0, int_req}, 32'h0);
    step();
    check("int_req_rises", {31'b0, int_req}, 32'h1);
    rd(CSR_ESTAT, EST | 32'h4, "estat_hw0");
    ipi_int = 1'b1;
    step();
    rd(CSR_ESTAT, EST | 32'h1004, "estat_ipi");
    wr(CSR_CRMD, 32'h0, 32'hFFFF_FFFF);
    check("int_req_ie_dropped", {31'b0, int_req}, 32'h0);

    // Asynchronous reset mid-countdown.
    wr(CSR_TCFG, 32'h13, 32'hFFFF_FFFF);
    repeat (3) step();
    reset = 1'b1;
    #2;
    rd(CSR_CRMD,  32'h8,         "async_crmd");
    rd(CSR_TVAL,  32'hFFFF_FFFF, "async_tval");
    rd(CSR_ESTAT, 32'h0,         "async_estat");
    rd(CSR_SAVE0 + 14'h1, 32'h0, "async_save1");
    rd(CSR_TCFG,  32'h0,         "async_tcfg");
    check("async_excp_entry", excp_entry, 32'h0);
    check("async_ertn_pc", ertn_pc, 32'h0);
    check("async_da", {31'b0, crmd_da}, 32'h1);
    check("async_int_req", {31'b0, int_req}, 32'h0);
    reset = 1'b0;
    hw_int = '0;
    ipi_int = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
